// File: rtl/key_cmd_pkg.sv
// Shared constants for the key command scheduler.
// Op codes, player IDs and the auto-repeat key mask.
package key_cmd_pkg;

  localparam logic [2:0] OP_LEFT   = 3'd0;
  localparam logic [2:0] OP_RIGHT  = 3'd1;
  localparam logic [2:0] OP_ROTATE = 3'd2;
  localparam logic [2:0] OP_CHANGE = 3'd3;
  localparam logic [2:0] OP_SPEED  = 3'd4;
  localparam logic [2:0] OP_DROP   = 3'd5;
  localparam logic [2:0] OP_ENTER  = 3'd6;
  localparam logic [2:0] OP_PAUSE  = 3'd7;

  localparam logic [1:0] PLY_P1  = 2'd0;
  localparam logic [1:0] PLY_P2  = 2'd1;
  localparam logic [1:0] PLY_SYS = 2'd2;

  localparam logic [5:0] REPEATABLE_MASK = 6'b010011;

  function automatic logic [2:0] lowest_op(input logic [5:0] v);
    lowest_op = '0;
    for (int i = 5; i >= 0; i--)
      if (v[i]) lowest_op = 3'(i);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Per-key press edge detector with delayed auto-repeat.
// evt pulses on a press and on every auto-repeat fire.
module key_repeat #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4,
  parameter int CNT_W     = 6,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key,
  input  logic inhibit,
  output logic evt
);

  localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DAS_DELAY - DAS_RATE);

  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic             held;
  logic             fire;

  assign press = key & ~prev;
  assign held  = key & prev;
  assign fire  = REPEAT_EN && held && !inhibit
              && tick && (cnt == FIRE_AT);
  assign evt   = press | fire;

  // prev tracks key even in reset so a held key never fires on release
  always_ff @(posedge clk) begin
    prev <= key;
    if (rst || !REPEAT_EN || !held || inhibit)
      cnt <= '0;
    else if (tick)
      cnt <= fire ? RELOAD : cnt + 1'b1;
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Key-to-command scheduler with DAS auto-repeat and round-robin issue.
// Optional SOCD_LAST_WIN_EN: last-pressed of LEFT/RIGHT wins repeat.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [5:0] p1_keys,
  input  logic [5:0] p2_keys,
  input  logic [1:0] sys_keys,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_player,
  output logic [2:0] cmd_op,
  output logic       cmd_drop
);

  logic [5:0] evt_p1, evt_p2;
  logic [1:0] evt_sys;
  logic [5:0] inh_p1, inh_p2;
  logic [5:0] pend_p1, pend_p2;
  logic [1:0] pend_sys;
  logic [5:0] gnt_p1, gnt_p2;
  logic [1:0] gnt_sys;
  logic       gnt_vld;
  logic [1:0] gnt_player;
  logic [2:0] gnt_op;
  logic       rr_p2;
  logic       slot_free;
  logic       pick_p1, pick_p2;

  for (genvar i = 0; i < 6; i++) begin : g_ply
    key_repeat #(
      .DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE),
      .CNT_W(CNT_W), .REPEAT_EN(REPEATABLE_MASK[i])
    ) u_p1 (
      .clk(clk), .rst(rst), .tick(tick),
      .key(p1_keys[i]), .inhibit(inh_p1[i]),
      .evt(evt_p1[i])
    );
    key_repeat #(
      .DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE),
      .CNT_W(CNT_W), .REPEAT_EN(REPEATABLE_MASK[i])
    ) u_p2 (
      .clk(clk), .rst(rst), .tick(tick),
      .key(p2_keys[i]), .inhibit(inh_p2[i]),
      .evt(evt_p2[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_sys
    key_repeat #(
      .DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE),
      .CNT_W(CNT_W), .REPEAT_EN(1'b0)
    ) u_sys (
      .clk(clk), .rst(rst), .tick(tick),
      .key(sys_keys[i]), .inhibit(1'b0),
      .evt(evt_sys[i])
    );
  end

`ifdef SOCD_LAST_WIN_EN
  logic [1:0] lr_prev_p1, lr_prev_p2;
  logic       last_r_p1, last_r_p2;
  logic       now_r_p1, now_r_p2;
  logic [1:0] rise_p1, rise_p2;

  assign rise_p1 = p1_keys[1:0] & ~lr_prev_p1;
  assign rise_p2 = p2_keys[1:0] & ~lr_prev_p2;

  // a fresh press takes effect in the same cycle it is seen
  always_comb begin
    now_r_p1 = last_r_p1;
    now_r_p2 = last_r_p2;
    if (rise_p1[1])      now_r_p1 = 1'b1;
    else if (rise_p1[0]) now_r_p1 = 1'b0;
    if (rise_p2[1])      now_r_p2 = 1'b1;
    else if (rise_p2[0]) now_r_p2 = 1'b0;
  end

  assign inh_p1 = {4'b0, p1_keys[0] & ~now_r_p1,
                   p1_keys[1] & now_r_p1};
  assign inh_p2 = {4'b0, p2_keys[0] & ~now_r_p2,
                   p2_keys[1] & now_r_p2};

  always_ff @(posedge clk) begin
    lr_prev_p1 <= p1_keys[1:0];
    lr_prev_p2 <= p2_keys[1:0];
    if (rst) begin
      last_r_p1 <= 1'b0;
      last_r_p2 <= 1'b0;
    end else begin
      last_r_p1 <= now_r_p1;
      last_r_p2 <= now_r_p2;
    end
  end
`else
  assign inh_p1 = '0;
  assign inh_p2 = '0;
`endif

  assign slot_free = !cmd_valid || cmd_ready;
  assign pick_p1 = (|pend_p1) && (!rr_p2 || !(|pend_p2));
  assign pick_p2 = (|pend_p2) && !pick_p1;

  always_comb begin
    gnt_p1     = '0;
    gnt_p2     = '0;
    gnt_sys    = '0;
    gnt_vld    = 1'b0;
    gnt_player = PLY_P1;
    gnt_op     = OP_LEFT;
    if (slot_free) begin
      if (pend_sys[1]) begin
        gnt_sys    = 2'b10;
        gnt_vld    = 1'b1;
        gnt_player = PLY_SYS;
        gnt_op     = OP_PAUSE;
      end else if (pend_sys[0]) begin
        gnt_sys    = 2'b01;
        gnt_vld    = 1'b1;
        gnt_player = PLY_SYS;
        gnt_op     = OP_ENTER;
      end else if (pick_p1) begin
        gnt_op     = lowest_op(pend_p1);
        gnt_p1     = 6'(1) << gnt_op;
        gnt_vld    = 1'b1;
        gnt_player = PLY_P1;
      end else if (pick_p2) begin
        gnt_op     = lowest_op(pend_p2);
        gnt_p2     = 6'(1) << gnt_op;
        gnt_vld    = 1'b1;
        gnt_player = PLY_P2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p1    <= '0;
      pend_p2    <= '0;
      pend_sys   <= '0;
      rr_p2      <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_player <= PLY_P1;
      cmd_op     <= OP_LEFT;
      cmd_drop   <= 1'b0;
    end else begin
      // a new event on a key being granted survives the grant
      pend_p1  <= (pend_p1 & ~gnt_p1) | evt_p1;
      pend_p2  <= (pend_p2 & ~gnt_p2) | evt_p2;
      pend_sys <= (pend_sys & ~gnt_sys) | evt_sys;
      cmd_drop <= |{evt_p1 & pend_p1 & ~gnt_p1,
                    evt_p2 & pend_p2 & ~gnt_p2,
                    evt_sys & pend_sys & ~gnt_sys};
      if (slot_free) begin
        cmd_valid <= gnt_vld;
        if (gnt_vld) begin
          cmd_player <= gnt_player;
          cmd_op     <= gnt_op;
        end
      end
      if (gnt_vld && gnt_player == PLY_P1) rr_p2 <= 1'b1;
      if (gnt_vld && gnt_player == PLY_P2) rr_p2 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler (default build).
// Immediate assertions at every comparison point.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [5:0] p1_keys;
  logic [5:0] p2_keys;
  logic [1:0] sys_keys;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_player;
  logic [2:0] cmd_op;
  logic       cmd_drop;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int base;
  logic [1:0] hs_player = '0;
  logic [2:0] hs_op = '0;

  key_cmd_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .p1_keys(p1_keys), .p2_keys(p2_keys),
    .sys_keys(sys_keys),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_player(cmd_player), .cmd_op(cmd_op),
    .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && cmd_valid && cmd_ready) begin
      hs_cnt++;
      hs_player = cmd_player;
      hs_op = cmd_op;
    end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cmd_ready = 1'b0;
    p1_keys = '0; p2_keys = '0; sys_keys = '0;
    step(3);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_player", 32'(cmd_player), 0);
    check("rst_op", 32'(cmd_op), 0);
    check("rst_drop", 32'(cmd_drop), 0);
    rst = 1'b0;
    step();

    // single-cycle ROTATE press
    cmd_ready = 1'b1;
    p1_keys = 6'b000100;
    step();
    check("t1_wait", 32'(cmd_valid), 0);
    p1_keys = '0;
    step();
    check("t1_valid", 32'(cmd_valid), 1);
    check("t1_player", 32'(cmd_player), 0);
    check("t1_op", 32'(cmd_op), 2);
    step();
    check("t1_once", 32'(cmd_valid), 0);
    step(3);
    check("t1_quiet", 32'(cmd_valid), 0);

    // P2 LEFT held for 30 ticks
    base = hs_cnt;
    p2_keys = 6'b000001;
    step();
    for (int k = 1; k <= 30; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step(3);
      if (k == 15) check("t2_pre_das", 32'(hs_cnt - base), 1);
      if (k == 16) check("t2_first_rep", 32'(hs_cnt - base), 2);
      if (k == 20) check("t2_second_rep", 32'(hs_cnt - base), 3);
    end
    p2_keys = '0;
    step(4);
    check("t2_total", 32'(hs_cnt - base), 5);
    check("t2_player", 32'(hs_player), 1);
    check("t2_op", 32'(hs_op), 0);

    // simultaneous DROP/DROP/PAUSE while stalled
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    cmd_ready = 1'b0;
    p1_keys = 6'b100000;
    p2_keys = 6'b100000;
    sys_keys = 2'b10;
    step();
    p1_keys = '0; p2_keys = '0; sys_keys = '0;
    step();
    check("t3_valid", 32'(cmd_valid), 1);
    check("t3_player", 32'(cmd_player), 2);
    check("t3_op", 32'(cmd_op), 7);
    step(2);
    check("t3_hold_valid", 32'(cmd_valid), 1);
    check("t3_hold_player", 32'(cmd_player), 2);
    check("t3_hold_op", 32'(cmd_op), 7);
    cmd_ready = 1'b1;
    step();
    check("t3_p1_player", 32'(cmd_player), 0);
    check("t3_p1_op", 32'(cmd_op), 5);
    step();
    check("t3_p2_valid", 32'(cmd_valid), 1);
    check("t3_p2_player", 32'(cmd_player), 1);
    check("t3_p2_op", 32'(cmd_op), 5);
    step();
    check("t3_idle", 32'(cmd_valid), 0);

    // CHANGE pressed twice while slot is stalled
    cmd_ready = 1'b0;
    p1_keys = 6'b000100;
    step();
    p1_keys = '0;
    step();
    check("t4_busy_op", 32'(cmd_op), 2);
    p1_keys = 6'b001000;
    step();
    check("t4_no_drop", 32'(cmd_drop), 0);
    p1_keys = '0;
    step();
    p1_keys = 6'b001000;
    step();
    check("t4_drop", 32'(cmd_drop), 1);
    p1_keys = '0;
    step();
    check("t4_drop_end", 32'(cmd_drop), 0);
    cmd_ready = 1'b1;
    step();
    check("t4_chg_valid", 32'(cmd_valid), 1);
    check("t4_chg_op", 32'(cmd_op), 3);
    step();
    check("t4_single", 32'(cmd_valid), 0);

    // SPEED held through reset
    p1_keys = 6'b010000;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(5);
    check("t5_no_cmd", 32'(cmd_valid), 0);
    p1_keys = '0;
    step();
    p1_keys = 6'b010000;
    step();
    check("t5_pend", 32'(cmd_valid), 0);
    step();
    check("t5_valid", 32'(cmd_valid), 1);
    check("t5_player", 32'(cmd_player), 0);
    check("t5_op", 32'(cmd_op), 4);
    p1_keys = '0;
    step(2);

    // reset abandons an in-flight command and pending state
    cmd_ready = 1'b0;
    sys_keys = 2'b01;
    step();
    sys_keys = '0;
    step();
    check("t6_valid", 32'(cmd_valid), 1);
    check("t6_player", 32'(cmd_player), 2);
    check("t6_op", 32'(cmd_op), 6);
    p1_keys = 6'b000010;
    step();
    p1_keys = '0;
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(cmd_valid), 0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    step(3);
    check("t6_no_pending", 32'(cmd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_cmd_scheduler.md
Name: key_cmd_scheduler

Overview:
- Converts raw level key states into discrete game commands for the two-player Tetris core, after key decoding and before the game engine.
- Per key: edge detection plus delayed auto-repeat (DAS) for LEFT/RIGHT/SPEED, timed by a frame tick.
- Pending commands from P1, P2 and system keys (ENTER/PAUSE) share a single command port to the game core, using a valid/ready handshake.

Parameters:
- DAS_DELAY, 16: ticks a repeatable key must be held before the first auto-repeat.
- DAS_RATE, 4: ticks between subsequent auto-repeats.
- CNT_W, 6: repeat counter width; must satisfy DAS_DELAY+DAS_RATE < 2**CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle frame pulse (e.g. 60 Hz) timing auto-repeat.
- p1_keys  in  6  level key states for P1, bit = op code (0 LEFT, 1 RIGHT, 2 ROTATE, 3 CHANGE, 4 SPEED, 5 DROP).
- p2_keys  in  6  same layout for P2.
- sys_keys  in  2  bit0 ENTER, bit1 PAUSE.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  game core accepts the command.
- cmd_player  out  2  0 = P1, 1 = P2, 2 = system.
- cmd_op  out  3  0-5 player ops as above; 6 = ENTER, 7 = PAUSE.
- cmd_drop  out  1  one-cycle pulse when a key event coalesces into an already-pending command.

Behaviour:
- Reset:
  - cmd_valid=0, cmd_player=0, cmd_op=0, cmd_drop=0.
  - All pending bits and repeat counters are cleared; the round-robin pointer points to P1.
  - During rst, the previous-key registers load the current key values, so keys held through reset do not fire on release.
- Edge detection:
  - prev_keys is registered every cycle.
  - A rising edge (key & ~prev) is a press event and sets that key's pending bit on the next clock.
- Auto-repeat (LEFT, RIGHT, SPEED only):
  - The counter clears on a press edge.
  - It increments on each tick while the key is held.
  - On reaching DAS_DELAY it fires a repeat event and reloads to DAS_DELAY-DAS_RATE, so subsequent fires occur every DAS_RATE ticks.
  - Release clears the counter immediately.
  - ROTATE, CHANGE, DROP, ENTER and PAUSE never repeat.
- Coalescing:
  - An event for a key whose pending bit is already set is lost and pulses cmd_drop for one cycle.
  - One event per key per cycle at most.
- Arbitration:
  - Occurs whenever the output slot is free (!cmd_valid, or cmd_valid&&cmd_ready in the same cycle).
  - System pending has absolute priority, PAUSE over ENTER.
  - Otherwise P1 and P2 are served round-robin. The pointer moves to the other player after that player is granted. A player with nothing pending is skipped.
  - Within a player, the lowest set op bit wins.
- Output register:
  - The granted pending bit clears in the same clock edge that loads cmd_player/cmd_op and sets cmd_valid.
  - Back-to-back issue is allowed: a new command loads in the same cycle the previous one handshakes.
- Handshake:
  - cmd_valid, cmd_player and cmd_op are held stable while cmd_valid && !cmd_ready.
  - cmd_valid never drops without a handshake, except on rst.
- Latency: key rises in cycle N → pending set at edge N+1 → cmd_valid high from cycle N+2 if the slot is idle.
- Simultaneous events:
  - A press and a grant of the same key in one cycle leave the pending bit set (the new event survives).
  - A tick coinciding with a press edge: the edge wins and the counter = 0.
- Reset mid-transaction: the command is abandoned, cmd_valid falls the next cycle, and no pending state survives.

Optional Feature:
- Macro SOCD_LAST_WIN_EN.
- Defined:
  - If LEFT and RIGHT of the same player are both held, only the most recently pressed direction auto-repeats.
  - The other direction's counter is held at 0 until the winning direction is released. It then restarts from 0, with no immediate fire.
- Undefined: both directions auto-repeat independently.

Decomposition:
- Shared package key_cmd_pkg holds:
  - op code constants (OP_LEFT..OP_PAUSE);
  - player IDs (PLY_P1, PLY_P2, PLY_SYS);
  - a REPEATABLE_MASK constant 6'b010011.
- One natural sub-module, key_repeat:
  - parameterised by DAS_DELAY, DAS_RATE, CNT_W and a REPEAT_EN bit;
  - inputs clk, rst, tick, key, inhibit;
  - output event pulse;
  - instantiated 14 times.

Test Plan:
1. Press P1 ROTATE for 1 cycle, cmd_ready=1 → cmd_valid for exactly 1 cycle, 2 cycles after press, with player=0, op=2; no second command on release.
2. Hold P2 LEFT for 30 ticks, cmd_ready=1 → exactly 5 commands (player=1, op=0): at press, then at ticks 16, 20, 24, 28.
3. cmd_ready=0 with P1 DROP, P2 DROP and PAUSE all pressed in one cycle, then ready=1 → issue order PAUSE(2,7), P1 DROP(0,5), P2 DROP(1,5); payload stable while stalled.
4. cmd_ready=0, press P1 CHANGE, release, press again → second press pulses cmd_drop; only one CHANGE is issued after ready=1.
5. Hold P1 SPEED through rst, then deassert rst → no command issued; a later release and press issues (0,4).
6. With SOCD_LAST_WIN_EN: hold P1 LEFT 20 ticks, press RIGHT, hold 20 ticks → RIGHT edge plus RIGHT repeats at +16 and +20; no LEFT repeats after the RIGHT press.
